spi_txn_arbiter: RTL and testbench

//   Shares one 8-bit SPI master between NUM_REQ requesters. Round-robin grant,
//   one byte transaction per grant. Sequences master start/done, returns the

---
 rtl/spi_arb_pkg.sv | 18 +
 rtl/spi_txn_arbiter_rr.sv | 39 +++
 rtl/spi_txn_arbiter.sv | 170 +++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI transaction arbiter.
//   state_t    : arbiter FSM states (3-bit encoding)
//   SPI_BYTE_W : width of one SPI transfer
//   ERR_BYTE   : rx byte reported for an aborted transaction
package spi_arb_pkg;

  localparam int SPI_BYTE_W = 8;
  localparam logic [SPI_BYTE_W-1:0] ERR_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    RESP   = 3'd3,
    GAP    = 3'd4
  } state_t;

endpackage

// File: rtl/spi_txn_arbiter_rr.sv
// Combinational round-robin arbiter.
//   req       : request vector, one bit per requester
//   last      : index of the most recently served requester
//   grant     : one-hot grant (all zero when nothing is requested)
//   grant_idx : binary index of the granted requester
//   any       : at least one request is present
// The search starts at last+1 and wraps, so the requester just served has
// the lowest priority on the next decision.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // NOTE: every signal written here gets a default before the loop; a path
  // that leaves one unassigned would make synthesis infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last) + off) % NUM_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one 8-bit SPI master between NUM_REQ requesters, one byte per grant.
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort a transaction whose
// spi_done never arrives (rsp_err=1, rsp_data=ERR_BYTE).
//   clk, rst       : clock, asynchronous active-low reset
//   req_valid/data : per-requester request and tx byte ([8i+7:8i])
//   req_ready      : one-hot accept pulse, same cycle as the grant decision
//   rsp_valid/data : one-hot response pulse with the received byte
//   rsp_err        : response is an abort (always 0 without the timeout)
//   spi_start      : one-cycle start pulse to the SPI master
//   spi_tx_data    : byte to shift out, held from grant until the next grant
//   spi_done       : master finished, spi_rx_data valid
//   busy           : FSM is anywhere but IDLE
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [SPI_BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [SPI_BYTE_W-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          spi_start,
  output logic [SPI_BYTE_W-1:0]         spi_tx_data,
  input  logic                          spi_done,
  input  logic [SPI_BYTE_W-1:0]         spi_rx_data,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        grant_q, last_q, arb_idx;
  logic [NUM_REQ-1:0]      arb_gnt;
  logic                    arb_any;
  logic [SPI_BYTE_W-1:0]   tx_q, rx_q, tx_sel;
  logic [GAP_W-1:0]        gap_cnt;
  logic                    gap_done;
  logic                    to_expire;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req       (req_valid),
    .last      (last_q),
    .grant     (arb_gnt),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    tx_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) tx_sel = req_data[i*SPI_BYTE_W +: SPI_BYTE_W];
    end
  end

  assign gap_done = (gap_cnt == GAP_LAST);

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  // The count starts in LAUNCH, so the abort response lands exactly
  // TIMEOUT_CYCLES cycles after the start pulse.
  assign to_expire = (state_q == WAIT) && (to_cnt >= TO_LAST);
  assign rsp_err   = (state_q == RESP) && err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          to_cnt <= '0;
          err_q  <= 1'b0;
        end
        LAUNCH: if (to_cnt != '1) to_cnt <= to_cnt + 1'b1;
        WAIT: begin
          if (to_cnt != '1) to_cnt <= to_cnt + 1'b1;
          // A done in the expiry cycle still counts as a normal completion.
          if (spi_done)       err_q <= 1'b0;
          else if (to_expire) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  assign to_expire = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    spi_start = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready = arb_gnt;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        spi_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (spi_done || to_expire) state_d = RESP;
      end
      RESP: begin
        rsp_valid = NUM_REQ'(1) << grant_q;
        state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      tx_q    <= '0;
      rx_q    <= '0;
      gap_cnt <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            grant_q <= arb_idx;
            tx_q    <= tx_sel;
          end
        end
        WAIT: begin
          if (spi_done)       rx_q <= spi_rx_data;
          else if (to_expire) rx_q <= ERR_BYTE;
        end
        RESP: begin
          last_q  <= grant_q;
          gap_cnt <= '0;
        end
        GAP: if (gap_cnt != '1) gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign spi_tx_data = tx_q;
  assign rsp_data    = rx_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter (NUM_REQ=4, GAP_CYCLES=16,
// TIMEOUT_CYCLES=64). Inputs change on the falling edge; outputs are read
// 1 time unit later, mid-cycle.
module tb_spi_txn_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        spi_start;
  logic [7:0]  spi_tx_data;
  logic        spi_done;
  logic [7:0]  spi_rx_data;
  logic        busy;

  spi_txn_arbiter #(.NUM_REQ(4), .GAP_CYCLES(16), .TIMEOUT_CYCLES(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .spi_start   (spi_start),
    .spi_tx_data (spi_tx_data),
    .spi_done    (spi_done),
    .spi_rx_data (spi_rx_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int last_start = -1;
  int prev_delay = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [7:0]  tx;
    logic [7:0]  rx;
    int          delay;
    int          exp_g;
    bit          hold;
    bit          spur;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One full transaction, entered mid-cycle with the DUT expected in IDLE.
  task automatic run_txn(input vec_t v);
    int waited;
    @(negedge clk);
    spi_done  = 1'b0;
    req_valid = v.req;
    req_data  = v.data;
    #1;
    check("idle_before_grant", busy, 0);
    waited = 0;
    while (req_ready == 0 && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    check("grant", req_ready, 32'd1 << v.exp_g);
    @(negedge clk);
    if (!v.hold) req_valid = '0;
    #1;
    check("start", spi_start, 1);
    check("tx_data", spi_tx_data, v.tx);
    check("ready_in_launch", req_ready, 0);
    if (last_start >= 0) check("start_spacing", cyc - last_start, prev_delay + 19);
    last_start = cyc;
    prev_delay = v.delay;
    for (int k = 1; k < v.delay; k++) begin
      @(negedge clk); #1;
      check("wait_quiet", {spi_start, rsp_valid, req_ready}, 0);
    end
    @(negedge clk);
    spi_done    = 1'b1;
    spi_rx_data = v.rx;
    #1;
    check("tx_hold", spi_tx_data, v.tx);
    @(negedge clk);
    spi_done    = 1'b0;
    spi_rx_data = ~v.rx;
    #1;
    check("rsp_valid", rsp_valid, 32'd1 << v.exp_g);
    check("rsp_data", rsp_data, v.rx);
    check("rsp_err", rsp_err, 0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      spi_done = v.spur && (k == 5);
      #1;
      check("gap_quiet", {spi_start, rsp_valid, req_ready}, 0);
      check("gap_busy", busy, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b0010, 32'h0000_A500, 8'hA5, 8'h3C, 20, 1, 1'b0, 1'b0};
    vecs[1] = '{4'b1000, 32'h7E00_0000, 8'h7E, 8'h81,  3, 3, 1'b0, 1'b0};
    vecs[2] = '{4'hF,    32'h4433_2211, 8'h11, 8'h01,  2, 0, 1'b1, 1'b0};
    vecs[3] = '{4'hF,    32'h4433_2211, 8'h22, 8'h02,  5, 1, 1'b1, 1'b0};
    vecs[4] = '{4'hF,    32'h8877_6655, 8'h77, 8'h03,  1, 2, 1'b1, 1'b1};
    vecs[5] = '{4'hF,    32'h8877_6655, 8'h88, 8'h04,  7, 3, 1'b1, 1'b0};
    vecs[6] = '{4'hF,    32'hC3C2_C1C0, 8'hC0, 8'h05,  4, 0, 1'b1, 1'b0};
    vecs[7] = '{4'hF,    32'hC3C2_C1C0, 8'hC1, 8'h06,  2, 1, 1'b1, 1'b0};
    vecs[8] = '{4'hF,    32'hC3C2_C1C0, 8'hC2, 8'h07,  6, 2, 1'b1, 1'b0};
    vecs[9] = '{4'hF,    32'hC3C2_C1C0, 8'hC3, 8'h5A,  3, 3, 1'b0, 1'b0};

    rst = 1'b0; req_valid = '0; req_data = '0; spi_done = 1'b0; spi_rx_data = '0;
    @(negedge clk); #1;
    check("reset_busy", busy, 0);
    check("reset_outputs", {req_ready, rsp_valid, rsp_err, spi_start}, 0);
    check("reset_data", {spi_tx_data, rsp_data}, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Spurious done while idle: no response, no state change.
    @(negedge clk);
    spi_done = 1'b1; #1;
    check("idle_spur_busy", busy, 0);
    @(negedge clk);
    spi_done = 1'b0; #1;
    check("idle_spur_quiet", {busy, rsp_valid, spi_start}, 0);
    check("idle_spur_data", rsp_data, 8'h5A);
    last_start = -1;

    // Reset while in WAIT.
    @(negedge clk);
    req_valid = 4'b0100; req_data = 32'h00EE_0000; #1;
    check("rst_txn_grant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0; #1;
    check("rst_txn_start", spi_start, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0; #1;
    check("rst_mid_outputs", {busy, req_ready, rsp_valid, rsp_err, spi_start}, 0);
    check("rst_mid_data", {spi_tx_data, rsp_data}, 0);
    @(negedge clk); #1;
    check("rst_hold_quiet", {busy, rsp_valid}, 0);
    @(negedge clk);
    rst = 1'b1; spi_done = 1'b1; #1;
    check("rst_late_done", {busy, rsp_valid}, 0);
    run_txn('{4'hF, 32'hDDCC_BBAA, 8'hAA, 8'h99, 4, 0, 1'b0, 1'b0});

`ifdef SPI_ARB_TIMEOUT_EN
    // Master never answers: abort response 64 cycles after the start pulse.
    @(negedge clk);
    req_valid = 4'b0010; req_data = 32'h0000_5500; #1;
    check("to_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0; #1;
    check("to_start", spi_start, 1);
    for (int k = 1; k <= 63; k++) begin
      @(negedge clk); #1;
      check("to_wait_quiet", rsp_valid, 0);
    end
    @(negedge clk); #1;
    check("to_rsp_valid", rsp_valid, 4'b0010);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_data", rsp_data, 8'hFF);
    @(negedge clk);
    spi_done = 1'b1; spi_rx_data = 8'h12; #1;
    @(negedge clk);
    spi_done = 1'b0; #1;
    check("to_late_done", {rsp_valid, rsp_err}, 0);
    check("to_late_data", rsp_data, 8'hFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
